sorting_data_memory: RTL and testbench
======================================

# sorting_data_memory

Parametrised successor to the processor's data memory. It is a byte-addressed, word-organised register-array memory with a built-in bubble-sort engine. The engine sorts the whole array in place on request, with early termination, so the processor or bench no longer runs the sort loop itself. It sits on the pipeline's MEM-stage port and also exposes every element for debug and visibility.

## Interface
Parameters:
- DATA_WIDTH, 64, word width in bits; multiple of 8, at least 8.
- DEPTH, 8, number of words; at least 2.
- SIGNED, 0, 1 = compare as two's complement, 0 = unsigned.
- DESCENDING, 0, 1 = largest word at index 0, 0 = smallest word at index 0.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- address  in  64  byte address; word index = address >> log2(DATA_WIDTH/8); low offset bits ignored.
- write_data  in  DATA_WIDTH  store data.
- memoryread  in  1  read enable.
- memorywrite  in  1  write enable.
- read_data  out  DATA_WIDTH  load data.
- sort_start  in  1  request an in-place sort.
- sort_busy  out  1  high while the sort is running.
- sort_done  out  1  one-cycle completion pulse.
- swap_count  out  32  number of swaps in the current or last sort.
- elements  out  DEPTH*DATA_WIDTH  flat view of the array; word k is at bits [k*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Reset clears all words, swap_count, sort_busy and sort_done to 0 and sets the state to IDLE.
- read_data is combinational:
  - memoryread=1 and index < DEPTH: read_data = mem[index].
  - Otherwise read_data = 0.
- Writes commit at the rising edge when memorywrite=1, index < DEPTH and the state is IDLE or DONE. Out-of-range writes are dropped.
- While sort_busy=1, writes are silently dropped. Reads still return the live array contents.
- The state machine has three states: IDLE, SORT and DONE.
  - IDLE → SORT when sort_start=1. On entry: pass i=0, index j=0, pass-swap flag cleared, swap_count cleared.
  - SORT performs one compare per cycle on mem[j] and mem[j+1]. The pair swaps in that same edge when it is out of order:
    - Ascending: swap when mem[j] > mem[j+1].
    - Descending: swap when mem[j] < mem[j+1].
    - Equal words never swap.
  - Each swap increments swap_count and sets the pass-swap flag.
  - Pass i spans j = 0 … DEPTH-2-i.
  - At the end of a pass, go to DONE if no swap occurred in that pass or if i = DEPTH-2. Otherwise set i=i+1, j=0 and clear the flag.
  - DONE → IDLE unconditionally.
- sort_start is ignored in SORT and in DONE.
- A write and sort_start in the same IDLE cycle: the write commits at that edge and the sort sees the new value.

## Timing
- The sort_start edge at cycle k sets sort_busy=1 from k+1.
- SORT lasts C cycles, where C is the total number of compares:
  - Best case (already sorted): C = DEPTH-1.
  - Worst case: C = DEPTH·(DEPTH-1)/2.
- Output registers: sort_busy = (state==SORT) and sort_done = (state==DONE). sort_done is high for exactly one cycle, at k+1+C.
- The first accepted write after a sort is at the DONE cycle edge.
- swap_count is stable from DONE until the next accepted sort_start.
- Reset asserted mid-sort takes effect immediately: the array is zeroed, the state is IDLE, no sort_done pulse is produced and partial results are lost.

## Test plan
- Reset then read: assert reset mid-run, read all 8 words at addresses 0, 8, …, 56 → every word reads 0 and sort_busy=sort_done=0.
- Reverse order, default parameters: write 8,7,6,5,4,3,2,1 at addresses 0…56, pulse sort_start → sort_busy for exactly 28 cycles, one sort_done pulse, array reads 1…8 and swap_count=28.
- Already sorted: write 1…8, start a sort → sort_busy for 7 cycles, swap_count=0, contents unchanged.
- Boundaries and duplicates: load 5,3,5,1,0xFFFF_FFFF_FFFF_FFFF,3,0,2 with SIGNED=0 → 0,1,2,3,3,5,5,0xFFFF… Repeat with SIGNED=1 → 0xFFFF… (−1) first. Repeat with DESCENDING=1, SIGNED=0 → reverse of the unsigned result.
- Busy-period protection: during the sort, write 99 to address 0 and pulse sort_start again → the write is absent from the final array, there is a single sort_done, and a read during the sort returns intermediate live data. Also check that address 64 reads 0 and a write to it is dropped.
- Reset mid-sort and a non-default build: assert reset at cycle 10 of a reverse sort → immediate IDLE with a zeroed array. Then instantiate DATA_WIDTH=32, DEPTH=4 with addresses 0, 4, 8, 12 and load 4,3,2,1 → 1,2,3,4 in 6 cycles with swap_count=6. Also check that write plus sort_start in the same cycle includes the written value.

Source files
------------

// File: rtl/sorting_data_memory.sv
// Byte-addressed, word-organised register-array memory with an in-place bubble-sort
// engine (one compare/swap per cycle, early exit when a pass makes no swaps).
module sorting_data_memory #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int SIGNED     = 0,
    parameter int DESCENDING = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [63:0]                 address,
    input  logic [DATA_WIDTH-1:0]       write_data,
    input  logic                        memoryread,
    input  logic                        memorywrite,
    output logic [DATA_WIDTH-1:0]       read_data,
    input  logic                        sort_start,
    output logic                        sort_busy,
    output logic                        sort_done,
    output logic [31:0]                 swap_count,
    output logic [DEPTH*DATA_WIDTH-1:0] elements
);

    localparam int SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(DEPTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       i_q, i_d, j_q, j_d;
    logic                   flag_q, flag_d;
    logic [31:0]            swap_count_q, swap_count_d;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]  mem_d [DEPTH];

    logic [63:0]            word_idx_s;
    logic                   in_range_s;
    logic [IDX_W-1:0]       idx_s, j_next_s;
    logic [DATA_WIDTH-1:0]  word_a_s, word_b_s;
    logic                   pair_swap_s;

    // True when the pair (a, b) violates the configured ordering; equal words never swap.
    function automatic logic out_of_order(input logic [DATA_WIDTH-1:0] a,
                                          input logic [DATA_WIDTH-1:0] b);
        logic a_gt_b;
        logic a_lt_b;
        if (SIGNED != 0) begin
            a_gt_b = $signed(a) > $signed(b);
            a_lt_b = $signed(a) < $signed(b);
        end else begin
            a_gt_b = a > b;
            a_lt_b = a < b;
        end
        if (DESCENDING != 0) begin
            return a_lt_b;
        end else begin
            return a_gt_b;
        end
    endfunction

    assign word_idx_s = address >> SHIFT;
    assign in_range_s = (word_idx_s < 64'(DEPTH));
    assign idx_s      = word_idx_s[IDX_W-1:0];
    assign j_next_s   = j_q + IDX_W'(1);
    assign word_a_s   = mem_q[j_q];
    assign word_b_s   = mem_q[j_next_s];

    assign sort_busy  = (state_q == ST_SORT);
    assign sort_done  = (state_q == ST_DONE);
    assign swap_count = swap_count_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_elem
        assign elements[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
    end

    // Combinational load port: live array contents, zero when disabled or out of range.
    always_comb begin
        read_data = '0;
        if (memoryread && in_range_s) begin
            read_data = mem_q[idx_s];
        end else begin
            read_data = '0;
        end
    end

    // Next-state logic: host writes in IDLE/DONE, one compare-and-swap per SORT cycle.
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        flag_d       = flag_q;
        swap_count_d = swap_count_q;
        mem_d        = mem_q;
        pair_swap_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (memorywrite && in_range_s) begin
                    mem_d[idx_s] = write_data;
                end else begin
                    mem_d[idx_s] = mem_q[idx_s];
                end
                if (sort_start) begin
                    state_d      = ST_SORT;
                    i_d          = '0;
                    j_d          = '0;
                    flag_d       = 1'b0;
                    swap_count_d = 32'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SORT: begin
                pair_swap_s = out_of_order(word_a_s, word_b_s);
                if (pair_swap_s) begin
                    mem_d[j_q]      = word_b_s;
                    mem_d[j_next_s] = word_a_s;
                    swap_count_d    = swap_count_q + 32'd1;
                    flag_d          = 1'b1;
                end else begin
                    flag_d = flag_q;
                end
                // Last compare of this pass decides between early exit and the next pass.
                if (j_q == (LAST_I - i_q)) begin
                    if (!(flag_q || pair_swap_s) || (i_q == LAST_I)) begin
                        state_d = ST_DONE;
                    end else begin
                        i_d    = i_q + IDX_W'(1);
                        j_d    = '0;
                        flag_d = 1'b0;
                    end
                end else begin
                    j_d = j_next_s;
                end
            end
            ST_DONE: begin
                if (memorywrite && in_range_s) begin
                    mem_d[idx_s] = write_data;
                end else begin
                    mem_d[idx_s] = mem_q[idx_s];
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, sort counters and array registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            i_q          <= '0;
            j_q          <= '0;
            flag_q       <= 1'b0;
            swap_count_q <= 32'd0;
            mem_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            flag_q       <= flag_d;
            swap_count_q <= swap_count_d;
            mem_q        <= mem_d;
        end
    end

endmodule

// File: tb/tb_sorting_data_memory.sv
// Directed bench: three 8x64 builds (unsigned/signed/descending) share stimulus,
// plus a 4x32 build for the narrow-word and write-with-start cases.
module tb_sorting_data_memory;

    localparam logic [63:0] M = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk, reset;
    logic [63:0]  address, write_data;
    logic         memoryread, memorywrite, sort_start;
    logic [63:0]  rd0, rd1, rd2;
    logic         busy0, busy1, busy2, done0, done1, done2;
    logic [31:0]  swc0, swc1, swc2;
    logic [511:0] el0, el1, el2;

    logic [63:0]  address_n;
    logic [31:0]  wdata_n, rd_n, swc_n;
    logic         mr_n, mw_n, ss_n, busy_n, done_n;
    logic [127:0] el_n;

    int checks = 0;
    int failures = 0;
    int busy_c, done_c;
    logic [63:0] d;

    sorting_data_memory dut0 (
        .clk(clk), .reset(reset), .address(address), .write_data(write_data),
        .memoryread(memoryread), .memorywrite(memorywrite), .read_data(rd0),
        .sort_start(sort_start), .sort_busy(busy0), .sort_done(done0),
        .swap_count(swc0), .elements(el0));

    sorting_data_memory #(.SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .address(address), .write_data(write_data),
        .memoryread(memoryread), .memorywrite(memorywrite), .read_data(rd1),
        .sort_start(sort_start), .sort_busy(busy1), .sort_done(done1),
        .swap_count(swc1), .elements(el1));

    sorting_data_memory #(.DESCENDING(1)) dut_d (
        .clk(clk), .reset(reset), .address(address), .write_data(write_data),
        .memoryread(memoryread), .memorywrite(memorywrite), .read_data(rd2),
        .sort_start(sort_start), .sort_busy(busy2), .sort_done(done2),
        .swap_count(swc2), .elements(el2));

    sorting_data_memory #(.DATA_WIDTH(32), .DEPTH(4)) dut_n (
        .clk(clk), .reset(reset), .address(address_n), .write_data(wdata_n),
        .memoryread(mr_n), .memorywrite(mw_n), .read_data(rd_n),
        .sort_start(ss_n), .sort_busy(busy_n), .sort_done(done_n),
        .swap_count(swc_n), .elements(el_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_arr(input string tag, input logic [511:0] el, input logic [511:0] exp);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s[%0d]", tag, k), el[k*64 +: 64], exp[k*64 +: 64]);
        end
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] v);
        address = a;
        write_data = v;
        memorywrite = 1'b1;
        @(posedge clk); #1;
        memorywrite = 1'b0;
    endtask

    task automatic rd(input logic [63:0] a, output logic [63:0] v);
        address = a;
        memoryread = 1'b1;
        #1;
        v = rd0;
        memoryread = 1'b0;
    endtask

    task automatic load8(input logic [511:0] v);
        for (int k = 0; k < 8; k++) begin
            wr(64'(k * 8), v[k*64 +: 64]);
        end
    endtask

    task automatic count_cycles(input int n, output int busy, output int dones);
        busy = 0;
        dones = 0;
        repeat (n) begin
            if (busy0) busy++;
            if (done0) dones++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_sort(output int busy, output int dones);
        sort_start = 1'b1;
        @(posedge clk); #1;
        sort_start = 1'b0;
        count_cycles(40, busy, dones);
    endtask

    initial begin
        reset = 1'b1;
        address = 64'd0; write_data = 64'd0;
        memoryread = 1'b0; memorywrite = 1'b0; sort_start = 1'b0;
        address_n = 64'd0; wdata_n = 32'd0; mr_n = 1'b0; mw_n = 1'b0; ss_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_swc", 64'(swc0), 64'd0);
        check_arr("rst_el", el0, 512'd0);
        reset = 1'b0;

        // Reverse order: worst case, 28 compares and 28 swaps.
        load8({64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8});
        run_sort(busy_c, done_c);
        check("rev_busy", 64'(busy_c), 64'd28);
        check("rev_done", 64'(done_c), 64'd1);
        check("rev_swc", 64'(swc0), 64'd28);
        for (int k = 0; k < 8; k++) begin
            rd(64'(k * 8), d);
            check($sformatf("rev_rd%0d", k), d, 64'(k + 1));
        end

        // Already sorted: one pass, no swaps.
        load8({64'd8, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1});
        run_sort(busy_c, done_c);
        check("srt_busy", 64'(busy_c), 64'd7);
        check("srt_done", 64'(done_c), 64'd1);
        check("srt_swc", 64'(swc0), 64'd0);
        check_arr("srt_el", el0, {64'd8, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1});

        // Duplicates and all-ones word across the three 64-bit builds.
        load8({64'd2, 64'd0, 64'd3, M, 64'd1, 64'd5, 64'd3, 64'd5});
        run_sort(busy_c, done_c);
        check("dup_done", 64'(done_c), 64'd1);
        check_arr("dup_u", el0, {M, 64'd5, 64'd5, 64'd3, 64'd3, 64'd2, 64'd1, 64'd0});
        check_arr("dup_s", el1, {64'd5, 64'd5, 64'd3, 64'd3, 64'd2, 64'd1, 64'd0, M});
        check_arr("dup_d", el2, {64'd0, 64'd1, 64'd2, 64'd3, 64'd3, 64'd5, 64'd5, M});
        check("dup_swc_u", 64'(swc0), 64'd18);
        check("dup_swc_s", 64'(swc1), 64'd19);
        check("dup_swc_d", 64'(swc2), 64'd8);

        // Writes and a second start during the sort are ignored; reads show live data.
        load8({64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8});
        sort_start = 1'b1;
        @(posedge clk); #1;
        sort_start = 1'b0;
        @(posedge clk); #1;
        rd(64'd0, d);
        check("live_rd0", d, 64'd7);
        rd(64'd8, d);
        check("live_rd1", d, 64'd8);
        address = 64'd0; write_data = 64'd99; memorywrite = 1'b1; sort_start = 1'b1;
        @(posedge clk); #1;
        memorywrite = 1'b0; sort_start = 1'b0;
        count_cycles(60, busy_c, done_c);
        check("prot_done", 64'(done_c), 64'd1);
        check("prot_swc", 64'(swc0), 64'd28);
        check_arr("prot_el", el0, {64'd8, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1});

        // Out-of-range and disabled accesses.
        wr(64'd64, 64'd77);
        rd(64'd64, d);
        check("oor_rd", d, 64'd0);
        check_arr("oor_el", el0, {64'd8, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1});
        address = 64'd8; memoryread = 1'b0; #1;
        check("noread", rd0, 64'd0);
        rd(64'd13, d);
        check("offset_rd", d, 64'd2);

        // Reset asserted ten cycles into a reverse sort.
        load8({64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8});
        sort_start = 1'b1;
        @(posedge clk); #1;
        sort_start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("mid_busy_pre", 64'(busy0), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_busy", 64'(busy0), 64'd0);
        check("mid_done", 64'(done0), 64'd0);
        check("mid_swc", 64'(swc0), 64'd0);
        for (int k = 0; k < 8; k++) begin
            rd(64'(k * 8), d);
            check($sformatf("mid_rd%0d", k), d, 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        count_cycles(5, busy_c, done_c);
        check("mid_nodone", 64'(done_c), 64'd0);

        // Narrow build: 4,3,2 written first, the final 1 written with sort_start.
        for (int k = 0; k < 3; k++) begin
            address_n = 64'(k * 4);
            wdata_n = 32'(4 - k);
            mw_n = 1'b1;
            @(posedge clk); #1;
            mw_n = 1'b0;
        end
        address_n = 64'd12; wdata_n = 32'd1; mw_n = 1'b1; ss_n = 1'b1;
        @(posedge clk); #1;
        mw_n = 1'b0; ss_n = 1'b0;
        busy_c = 0;
        done_c = 0;
        repeat (20) begin
            if (busy_n) busy_c++;
            if (done_n) done_c++;
            @(posedge clk); #1;
        end
        check("n_busy", 64'(busy_c), 64'd6);
        check("n_done", 64'(done_c), 64'd1);
        check("n_swc", 64'(swc_n), 64'd6);
        check("n_el_lo", el_n[63:0], {32'd2, 32'd1});
        check("n_el_hi", el_n[127:64], {32'd4, 32'd3});
        address_n = 64'd4; mr_n = 1'b1; #1;
        check("n_rd1", 64'(rd_n), 64'd2);
        mr_n = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
